// File: rtl/gun_pos_accum.sv
// Purpose : per-channel joystick-to-lightgun coordinate accumulator, stepping on the rising edge of a slow tick.
// Latency : positions update on the clk_sys edge that sees the tick event; moved pulses on that same edge.
// Backpressure: none; inputs are levels sampled every clock and outputs are plain registered levels.
// Optional feature: define GUN_ACCEL_EN to build the per-axis hold-acceleration run counter.
module gun_pos_accum #(
  parameter int CHANNELS    = 2,
  parameter int POS_W       = 6,
  parameter int STEP_DIV    = 3,
  parameter int ACCEL_AFTER = 4,
  parameter int ACCEL_STEP  = 4
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic [CHANNELS-1:0]       joy_left,
  input  logic [CHANNELS-1:0]       joy_right,
  input  logic [CHANNELS-1:0]       joy_up,
  input  logic [CHANNELS-1:0]       joy_down,
  input  logic [CHANNELS-1:0]       recenter,
  output logic [CHANNELS*POS_W-1:0] gun_h,
  output logic [CHANNELS*POS_W-1:0] gun_v,
  output logic [CHANNELS-1:0]       moved
);

  localparam int DIV_W = (STEP_DIV > 0) ? $clog2(STEP_DIV + 1) : 1;
  localparam int SZ_W  = POS_W + 1;
  localparam logic [POS_W-1:0] CENTRE  = POS_W'(1) << (POS_W - 1);
  localparam logic [POS_W:0]   MAX_EXT = {1'b0, {POS_W{1'b1}}};
  localparam logic [SZ_W-1:0]  UNIT    = SZ_W'(1);

  // Axis index i: 0..CHANNELS-1 are horizontal, CHANNELS..2*CHANNELS-1 vertical.
  logic                            tick_d;
  logic                            tick_ev;
  logic [2*CHANNELS-1:0]           neg_all;
  logic [2*CHANNELS-1:0]           pos_all;
  logic [2*CHANNELS-1:0]           chg;
  logic [2*CHANNELS*POS_W-1:0]     coord_all;

  assign neg_all = {joy_up, joy_left};
  assign pos_all = {joy_down, joy_right};
  assign tick_ev = tick & ~tick_d;

  // Delayed tick level: a tick held high yields exactly one event.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tick_d <= 1'b0;
    else          tick_d <= tick;
  end

  for (genvar i = 0; i < 2*CHANNELS; i++) begin : g_axis
    localparam int C = i % CHANNELS;

    logic              neg;
    logic              pos;
    logic              neg_r;
    logic              pos_r;
    logic              held;
    logic              step;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [POS_W-1:0]  coord_q;
    logic [POS_W-1:0]  coord_d;
    logic [POS_W:0]    ext;
    logic [POS_W:0]    sum;
    logic [SZ_W-1:0]   size;

    assign neg = neg_all[i];
    assign pos = pos_all[i];

`ifdef GUN_ACCEL_EN
    localparam int RUN_W = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
    logic [RUN_W-1:0] run_q;

    assign size = (run_q >= RUN_W'(ACCEL_AFTER)) ? SZ_W'(ACCEL_STEP) : UNIT;

    // Count steps within the current hold, saturating once acceleration is engaged.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)         run_q <= '0;
      else if (recenter[C]) run_q <= '0;
      else if (tick_ev) begin
        if (!held)                                      run_q <= '0;
        else if (step && (run_q < RUN_W'(ACCEL_AFTER))) run_q <= run_q + 1'b1;
      end
    end
`else
    assign size = UNIT;
`endif

    // Decide hold/step for this tick and compute the clamped next coordinate.
    always_comb begin
      held    = ~(neg & pos) & ((neg & neg_r) | (pos & pos_r));
      step    = (div_q == DIV_W'(1)) & (neg ^ pos);
      div_d   = (held && (div_q < DIV_W'(STEP_DIV))) ? div_q + 1'b1 : '0;
      ext     = {1'b0, coord_q};
      sum     = ext + size;
      coord_d = coord_q;
      if (recenter[C]) begin
        coord_d = CENTRE;
      end else if (tick_ev && step) begin
        if (neg) coord_d = (ext < size) ? '0 : POS_W'(ext - size);
        else     coord_d = (sum > MAX_EXT) ? '1 : sum[POS_W-1:0];
      end
    end

    // Coordinate, divider and previous-tick direction samples.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        coord_q <= CENTRE;
        div_q   <= '0;
        neg_r   <= 1'b0;
        pos_r   <= 1'b0;
      end else begin
        coord_q <= coord_d;
        if (recenter[C])  div_q <= '0;
        else if (tick_ev) div_q <= div_d;
        if (tick_ev) begin
          neg_r <= neg;
          pos_r <= pos;
        end
      end
    end

    assign coord_all[i*POS_W +: POS_W] = coord_q;
    assign chg[i] = (coord_d != coord_q);
  end

  assign gun_h = coord_all[CHANNELS*POS_W-1:0];
  assign gun_v = coord_all[2*CHANNELS*POS_W-1:CHANNELS*POS_W];

  // Pulse moved alongside any coordinate change of the channel.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) moved <= '0;
    else          moved <= chg[CHANNELS-1:0] | chg[2*CHANNELS-1:CHANNELS];
  end

endmodule

// File: tb/tb_gun_pos_accum.sv
// Bench for gun_pos_accum: a reference model predicts gun_h/gun_v/moved each clock,
// the monitor pops predictions and compares at the falling edge, plus a few absolute checkpoints.
module tb_gun_pos_accum;
  localparam int CH   = 2;
  localparam int PW   = 6;
  localparam int SD   = 3;
  localparam int AA   = 4;
  localparam int AS   = 4;
  localparam int CTR  = 32;
  localparam int MAXV = 63;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic            tick = 1'b0;
  logic [CH-1:0]   joy_left = '0, joy_right = '0, joy_up = '0, joy_down = '0;
  logic [CH-1:0]   recenter = '0;
  logic [CH*PW-1:0] gun_h, gun_v;
  logic [CH-1:0]   moved;

  gun_pos_accum #(.CHANNELS(CH), .POS_W(PW), .STEP_DIV(SD),
                  .ACCEL_AFTER(AA), .ACCEL_STEP(AS)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .tick(tick),
    .joy_left(joy_left), .joy_right(joy_right), .joy_up(joy_up), .joy_down(joy_down),
    .recenter(recenter), .gun_h(gun_h), .gun_v(gun_v), .moved(moved));

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [CH*PW-1:0] h;
    logic [CH*PW-1:0] v;
    logic [CH-1:0]    mv;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   checks = 0;
  int   failures = 0;

  // Model state: coordinate, consecutive-held-tick streak, steps in this hold, previous samples.
  int      m_pos[CH][2];
  int      m_streak[CH][2];
  int      m_run[CH][2];
  bit      m_nr[CH][2];
  bit      m_pr[CH][2];
  bit      m_tick_d;
  logic [CH-1:0] m_moved;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++)
      for (int a = 0; a < 2; a++) begin
        m_pos[c][a] = CTR; m_streak[c][a] = 0; m_run[c][a] = 0;
        m_nr[c][a] = 0;    m_pr[c][a] = 0;
      end
    m_tick_d = 0;
    m_moved  = '0;
  endfunction

  // One clock of behaviour: on a tick event, a hold of k consecutive held ticks steps when
  // k mod (STEP_DIV+1) == 1 before this tick; recenter overrides everything for its channel.
  function automatic void model_step();
    bit ev, n, p, held, fire;
    int old, sz;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ev = tick && !m_tick_d;
    for (int c = 0; c < CH; c++) begin
      m_moved[c] = 1'b0;
      for (int a = 0; a < 2; a++) begin
        n   = (a == 0) ? joy_left[c]  : joy_up[c];
        p   = (a == 0) ? joy_right[c] : joy_down[c];
        old = m_pos[c][a];
        if (ev) begin
          held = !(n && p) && ((n && m_nr[c][a]) || (p && m_pr[c][a]));
          fire = ((m_streak[c][a] % (SD + 1)) == 1) && (n != p);
          sz = 1;
`ifdef GUN_ACCEL_EN
          if (m_run[c][a] >= AA) sz = AS;
`endif
          if (fire) begin
            if (n) m_pos[c][a] = (old - sz < 0) ? 0 : old - sz;
            else   m_pos[c][a] = (old + sz > MAXV) ? MAXV : old + sz;
          end
          if (held) begin
            m_streak[c][a]++;
            if (fire && m_run[c][a] < AA) m_run[c][a]++;
          end else begin
            m_streak[c][a] = 0;
            m_run[c][a] = 0;
          end
          m_nr[c][a] = n;
          m_pr[c][a] = p;
        end
        if (recenter[c]) begin
          m_pos[c][a] = CTR; m_streak[c][a] = 0; m_run[c][a] = 0;
        end
        if (m_pos[c][a] != old) m_moved[c] = 1'b1;
      end
    end
    m_tick_d = tick;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      e.h[c*PW +: PW] = PW'(m_pos[c][0]);
      e.v[c*PW +: PW] = PW'(m_pos[c][1]);
    end
    e.mv = m_moved;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    model_step();
    e = model_out();
    @(posedge clk_sys);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic ticks(input int n, input int hi, input int lo);
    repeat (n) begin
      tick = 1'b1; repeat (hi) cycle();
      tick = 1'b0; repeat (lo) cycle();
    end
  endtask

  task automatic rcycle();
    recenter = ($urandom_range(0, 24) == 0) ? CH'($urandom) : '0;
    cycle();
  endtask

  // Monitor: every prediction is compared against what the DUT shows mid-cycle.
  always @(negedge clk_sys) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      check("sb_gun_h", 32'(gun_h), 32'(e_mon.h));
      check("sb_gun_v", 32'(gun_v), 32'(e_mon.v));
      check("sb_moved", 32'(moved), 32'(e_mon.mv));
    end
  end

  initial begin
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;
    repeat (2) cycle();
    check("reset_h0", 32'(gun_h[5:0]), 32);
    check("reset_v1", 32'(gun_v[11:6]), 32);
    check("reset_moved", 32'(moved), 0);

    // Right held on ch0: steps at ticks 3, 7, 11.
    joy_right[0] = 1'b1;
    ticks(11, 2, 2);
    check("hold_h0_t11", 32'(gun_h[5:0]), 35);
    check("hold_h1_idle", 32'(gun_h[11:6]), 32);

    // Ch1 left until clamped at 0, then keep holding.
    joy_right[0] = 1'b0;
    joy_left[1]  = 1'b1;
    ticks(140, 1, 1);
    check("clamp_h1_zero", 32'(gun_h[11:6]), 0);
    ticks(8, 1, 1);
    check("clamp_h1_hold", 32'(gun_h[11:6]), 0);

    // Left+right together: no movement.
    joy_left[1] = 1'b0;
    joy_left[0] = 1'b1; joy_right[0] = 1'b1;
    ticks(8, 1, 1);
    check("conflict_h0", 32'(gun_h[5:0]), 35);

    // Recenter coincident with the third tick (a step tick) of a fresh hold.
    joy_left[0] = 1'b0; joy_right[0] = 1'b0;
    ticks(2, 1, 1);
    joy_right[0] = 1'b1;
    ticks(2, 2, 2);
    tick = 1'b1; recenter[0] = 1'b1;
    cycle();
    check("recenter_h0", 32'(gun_h[5:0]), 32);
    check("recenter_moved0", 32'(moved[0]), 1);
    recenter[0] = 1'b0;
    cycle();
    tick = 1'b0;
    repeat (2) cycle();

    // Fresh hold from centre; first tick held high for many clocks.
    joy_right[0] = 1'b0;
    ticks(2, 1, 1);
    joy_right[0] = 1'b1;
    ticks(1, 10, 1);
    ticks(18, 1, 2);
`ifdef GUN_ACCEL_EN
    check("accel_h0_t19", 32'(gun_h[5:0]), 40);
`else
    check("accel_h0_t19", 32'(gun_h[5:0]), 37);
`endif
    ticks(4, 1, 1);
`ifdef GUN_ACCEL_EN
    check("accel_h0_t23", 32'(gun_h[5:0]), 44);
`else
    check("accel_h0_t23", 32'(gun_h[5:0]), 38);
`endif
    joy_right[0] = 1'b0;
    ticks(1, 1, 1);
    joy_right[0] = 1'b1;
    ticks(3, 1, 1);
`ifdef GUN_ACCEL_EN
    check("repress_h0", 32'(gun_h[5:0]), 45);
`else
    check("repress_h0", 32'(gun_h[5:0]), 39);
`endif

    // Asynchronous reset in the middle of a hold, then resume.
    ticks(3, 1, 1);
    @(negedge clk_sys); #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_h0", 32'(gun_h[5:0]), 32);
    check("async_rst_moved", 32'(moved), 0);
    repeat (2) cycle();
    reset_n = 1'b1;
    ticks(3, 1, 1);
    check("resume_h0", 32'(gun_h[5:0]), 33);

    // Randomized phase.
    repeat (250) begin
      if ($urandom_range(0, 3) == 0) begin
        joy_left  = CH'($urandom); joy_right = CH'($urandom);
        joy_up    = CH'($urandom); joy_down  = CH'($urandom);
      end
      tick = 1'b1; repeat ($urandom_range(1, 3)) rcycle();
      tick = 1'b0; repeat ($urandom_range(1, 3)) rcycle();
    end
    recenter = '0;
    cycle();

    @(negedge clk_sys); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gun_pos_accum.md
# gun_pos_accum

Multi-channel joystick-to-lightgun position accumulator for gun arcade cores. It converts digital joystick directions into absolute horizontal/vertical gun coordinates, stepping on a slow periodic tick supplied by the game board (the 4 ms counter output). It sits between the `hps_io` joystick decode and the game core's `gun_h`/`gun_v` inputs. It generalises the single-player fixed 6-bit scheme to N players, configurable width and step rate, recentring, and optional hold acceleration.

## Interface
Parameters:
- CHANNELS, 2, number of independent players/guns
- POS_W, 6, coordinate width per axis; range 0..2^POS_W-1
- STEP_DIV, 3, divider terminal value; steps occur every STEP_DIV+1 ticks while held
- ACCEL_AFTER, 4, consecutive steps before acceleration engages (used only with GUN_ACCEL_EN)
- ACCEL_STEP, 4, step size once accelerated (used only with GUN_ACCEL_EN)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  slow periodic level (4 ms counter bit); its rising edge is the step event
- joy_left, joy_right, joy_up, joy_down  in  CHANNELS each  active-high direction per channel
- recenter  in  CHANNELS  level; forces channel to centre
- gun_h, gun_v  out  CHANNELS*POS_W  channel c at bits [c*POS_W +: POS_W]
- moved  out  CHANNELS  one-clock pulse when that channel's h or v changed

## Operation
- Tick event: tick=1 while registered tick_d=0; tick_d updates every clock.
- Per channel, per axis (neg = left/up, pos = right/down), on tick event only:
  - dir_neg_r/dir_pos_r capture current inputs (previous-tick samples).
  - conflict = neg & pos; conflict treated as no input.
  - held = !conflict & ((neg & neg_r) | (pos & pos_r)).
  - div: held & div < STEP_DIV → div+1; else div ← 0. div width = clog2(STEP_DIV+1).
  - step fires when old div == 1 and exactly one of neg/pos asserted.
  - step applies −size (neg) or +size (pos), saturating at 0 and 2^POS_W−1; computed at POS_W+1 bits, then clamped.
- Without tick event: positions, div, direction samples hold.
- recenter[c]=1: that channel's h, v ← 2^(POS_W−1), div and run counters ← 0, every clock it is high; overrides a same-cycle tick step. Other channels unaffected.
- moved[c] = 1 for the clock after any h or v of channel c changes value (including recentre from off-centre); clamp-without-change does not pulse.
- Channels fully independent; no shared state except tick_d.

## Timing
- Reset (async assert, sync-safe release): gun_h, gun_v = 2^(POS_W−1) per channel; moved = 0; div, run, direction samples, tick_d = 0.
- Latency: position registered on the clk_sys edge where the tick event is seen; visible same cycle moved is high.
- Held input from idle, STEP_DIV=3: first step on 3rd tick event, then every 4th (ticks 3, 7, 11, …).
- Reset mid-hold: all state cleared; resumed hold restarts from tick 1 of the sequence.
- tick held high continuously produces exactly one event.

## Configuration
- GUN_ACCEL_EN defined: per-axis run counter (saturating, clog2(ACCEL_AFTER+1) bits) increments per step, clears when !held; step size = ACCEL_STEP once run ≥ ACCEL_AFTER, else 1.
- GUN_ACCEL_EN undefined: step size fixed at 1; run counter not built; ACCEL_* ignored.

## Test plan
- Reset defaults POS_W=6: after reset_n release both channels read h=v=32, moved=0.
- Ch0 right held, 11 tick events: h0 = 33 after tick 3, 34 after tick 7, 35 after tick 11; moved[0] pulses each; ch1 unchanged at 32.
- Ch1 left held from h=0 for 8 ticks: h1 stays 0, moved[1] never pulses; left+right together from 32 for 8 ticks: stays 32.
- Recenter: ch0 at h=40, v=10; recenter[0] asserted coincident with a step tick → h0=v0=32 next edge, moved[0]=1, no step applied.
- GUN_ACCEL_EN, ACCEL_AFTER=4, ACCEL_STEP=4: right held from 32 → 33,34,35,36 at ticks 3,7,11,15, then 40 at 19, 44 at 23; release one tick then re-press → steps return to size 1; saturates at 63.
- Reset asserted mid-hold at h=37: h returns to 32 asynchronously; after release, continued hold gives next step on 3rd tick event.
